// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex-to-segment decode for the scan driver
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble to active-low 7-segment pattern
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_hex7(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     dig,
  output logic [7:0]            segments,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic                sh_lz;

  logic                tick;
  logic                frame_end;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;
  logic [DIGITS-1:0]   onehot;
  logic [3:0]          nib;
  logic                dp_sel;
  logic                blank_sel;
  logic [6:0]          hex_seg;

  assign tick      = en && (cnt == CNT_MAX);
  assign frame_end = tick && (idx == IDX_MAX);

  // Walk from the most significant digit down; a digit is a leading zero
  // while it and everything above it are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (sh_data[4*i +: 4] == 4'h0);
      if (i > 0) lz_mask[i] = sh_lz & zero_above;
    end
  end

  always_comb begin
    onehot    = '0;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        onehot[i] = 1'b1;
        nib       = sh_data[4*i +: 4];
        dp_sel    = sh_dp[i];
        blank_sel = sh_blank[i] | lz_mask[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .nibble (nib),
    .seg    (hex_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_lz       <= 1'b0;
      dig         <= '1;
      segments    <= SEG_BLANK;
      frame_start <= 1'b0;
    end else if (!en) begin
      // Display dark and scan frozen; shadows track inputs so resume shows fresh data.
      sh_data     <= data;
      sh_dp       <= dp_in;
      sh_blank    <= blank_mask;
      sh_lz       <= lz_blank;
      dig         <= '1;
      segments    <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      if (frame_end) begin
        sh_data  <= data;
        sh_dp    <= dp_in;
        sh_blank <= blank_mask;
        sh_lz    <= lz_blank;
      end
      frame_start <= frame_end;
      dig         <= ~onehot;
      segments    <= {~dp_sel, blank_sel ? 7'h7F : hex_seg};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [3:0]  dig;
  logic [7:0]  segments;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  logic [3:0] cd [4];
  logic [7:0] cs [4];
  logic [3:0] exp_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .data        (data),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .lz_blank    (lz_blank),
    .dig         (dig),
    .segments    (segments),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_fs(output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 64) begin
      @(negedge clk);
      n++;
      if (frame_start) found = 1'b1;
    end
    if (!found) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture(input bit chg, input logic [15:0] nd);
    int n;
    wait_fs(n);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) @(negedge clk);
      else repeat (4) @(negedge clk);
      cd[k] = dig;
      cs[k] = segments;
      if (chg && k == 1) data = nd;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] es [4];
    es = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_dig%0d", tag, k), {28'd0, cd[k]}, {28'd0, exp_dig[k]});
      chk($sformatf("%s_seg%0d", tag, k), {24'd0, cs[k]}, {24'd0, es[k]});
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; data = 16'h1234; dp_in = 4'b0; blank_mask = 4'b0; lz_blank = 1'b0;

    // Reset and first slot
    repeat (3) @(negedge clk);
    chk("rst_dig", {28'd0, dig}, 32'hF);
    chk("rst_seg", {24'd0, segments}, 32'hFF);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_dig", {28'd0, dig}, 32'b1110);
    chk("first_seg", {24'd0, segments}, 32'hC0);
    repeat (3) @(negedge clk);
    chk("slot0_hold", {28'd0, dig}, 32'b1110);
    @(negedge clk);
    chk("slot1_dig", {28'd0, dig}, 32'b1101);

    // Full frame and period
    wait_fs(n);
    wait_fs(n);
    chk("frame_period", n, 32'd16);
    capture(1'b0, 16'h0);
    check_frame("f1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Anti-tear
    capture(1'b1, 16'hABCD);
    check_frame("tear_old", 8'h99, 8'hB0, 8'hA4, 8'hF9);
    capture(1'b0, 16'h0);
    check_frame("tear_new", 8'hA1, 8'hC6, 8'h83, 8'h88);

    // Leading-zero suppression
    lz_blank = 1'b1; data = 16'h0050;
    capture(1'b0, 16'h0);
    check_frame("lz0050", 8'hC0, 8'h92, 8'hFF, 8'hFF);
    data = 16'h0000;
    capture(1'b0, 16'h0);
    check_frame("lz0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Decimal point and blank mask
    lz_blank = 1'b0; data = 16'h1234; dp_in = 4'b0100;
    capture(1'b0, 16'h0);
    check_frame("dp2", 8'h99, 8'hB0, 8'h24, 8'hF9);
    blank_mask = 4'b0100;
    capture(1'b0, 16'h0);
    check_frame("blank2", 8'h99, 8'hB0, 8'h7F, 8'hF9);

    // Asynchronous reset mid-slot
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_dig", {28'd0, dig}, 32'hF);
    chk("async_seg", {24'd0, segments}, 32'hFF);
    @(negedge clk);
    dp_in = 4'b0; blank_mask = 4'b0; lz_blank = 1'b0; data = 16'h1234;
    rst = 1'b0;

    // Enable off for 10 clocks while on digit 2, then resume
    repeat (9) @(negedge clk);
    chk("pre_off_dig", {28'd0, dig}, 32'b1011);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("off_dig%0d", i), {28'd0, dig}, 32'hF);
      chk($sformatf("off_seg%0d", i), {24'd0, segments}, 32'hFF);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_dig", {28'd0, dig}, 32'b1011);
    chk("resume_seg", {24'd0, segments}, 32'hA4);
    repeat (2) @(negedge clk);
    chk("resume_hold", {28'd0, dig}, 32'b1011);
    @(negedge clk);
    chk("resume_next_dig", {28'd0, dig}, 32'b0111);
    chk("resume_next_seg", {24'd0, segments}, 32'hF9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
